// File: rtl/add_result_fifo.sv
// ---------------------------------------------------------------------------
// add_result_fifo
//
// Holds results from the 16-bit two's-complement adder until a slower
// consumer reads them. Each entry is {overflow, carry, s}. The read side
// is first-word fall-through: the head entry is always on out_* whenever
// out_valid is high.
//
// Ports
//   clk, rst           : clock and asynchronous active-high reset
//   in_valid/in_ready  : write handshake; in_s/in_carry/in_overflow payload
//   out_valid/out_ready: read handshake; out_s/out_carry/out_overflow = head
//   count              : number of stored entries (0..DEPTH)
//   ovf_sticky         : set by any accepted write with in_overflow = 1
//   clr_sticky         : synchronous clear of ovf_sticky (a set wins)
// ---------------------------------------------------------------------------
module add_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_carry,
    output logic             out_overflow,
    output logic [AW:0]      count,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Storage must clear on reset, so it is built from registers rather
    // than a RAM macro.
    logic [WIDTH+1:0] mem_reg [DEPTH];

    logic [AW-1:0] wp_reg;
    logic [AW-1:0] rp_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          ovf_sticky_reg;
    logic          ovf_sticky_next;

    logic wr_en;
    logic rd_en;

    // Flow control comes only from the registered count, so out_ready has
    // no path to in_ready and a full FIFO never accepts a write-through.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    assign {out_overflow, out_carry, out_s} = mem_reg[rp_reg];

    assign count      = count_reg;
    assign ovf_sticky = ovf_sticky_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wp_reg == AW'(gi))) begin
                    mem_reg[gi] <= {in_overflow, in_carry, in_s};
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Set has priority over clear so an overflow in the clearing cycle is
    // not lost.
    always_comb begin
        ovf_sticky_next = ovf_sticky_reg;
        if (wr_en && in_overflow) begin
            ovf_sticky_next = 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg         <= '0;
            rp_reg         <= '0;
            count_reg      <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (wr_en) begin
                wp_reg <= wp_reg + AW'(1);
            end
            if (rd_en) begin
                rp_reg <= rp_reg + AW'(1);
            end
            count_reg      <= count_next;
            ovf_sticky_reg <= ovf_sticky_next;
        end
    end

endmodule
